// File: rtl/game_flow_ctrl.sv
// Game sequencer: conditions start/flap/pause buttons, runs IDLE/PLAY/PAUSE/DEAD, tracks final and best score.
// Latency: raw button edge -> press 2 clk + DEB_TICKS ticks (+<=1 tick); press -> state/flap change 1 clk.
// Backpressure: none; every input is sampled each clk, and presses that are not legal in the current state are dropped.
//
// Ports: clk/clrn (async active-low reset), tick_1ms enable pulse, raw buttons btn_start/btn_up/btn_pause,
//        isDead collision level, score live score -> state bus, flap pulse, final_score, best_score,
//        new_best, restart_ok.
module game_flow_ctrl #(
    parameter int DEB_TICKS = 10,
    parameter int DEAD_HOLD = 1000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick_1ms,
    input  logic       btn_start,
    input  logic       btn_up,
    input  logic       btn_pause,
    input  logic       isDead,
    input  logic [7:0] score,
    output logic [1:0] state,
    output logic       flap,
    output logic [7:0] final_score,
    output logic [7:0] best_score,
    output logic       new_best,
    output logic       restart_ok
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_DEAD  = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(DEAD_HOLD + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(DEAD_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    // ---------------- button conditioning: bit 0 start, 1 up, 2 pause ----------------
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];

    assign raw = {btn_pause, btn_up, btn_start};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (tick_1ms) begin
                for (int i = 0; i < 3; i++) begin
                    // Any tick where the sample agrees with the accepted level restarts the count,
                    // so only DEB_TICKS consecutive disagreeing ticks flip the level.
                    if (sync2[i] == stable[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= ~stable[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
                    end
                end
            end
        end
    end

    // Rising edge of the accepted level only; releases produce nothing.
    assign press = stable & ~stable_d;

    logic start_press;
    logic up_press;
    logic pause_press;

    assign start_press = press[0];
    assign up_press    = press[1];
    assign pause_press = press[2];

    // ---------------- game FSM ----------------
    state_t        state_q;
    state_t        state_nxt;
    logic          flap_nxt;
    logic          die;
    logic          rearm;
    logic [HW-1:0] hold_cnt;

    always_comb begin
        state_nxt = state_q;
        flap_nxt  = 1'b0;
        die       = 1'b0;
        rearm     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (up_press) begin
                    state_nxt = S_PLAY;
                    flap_nxt  = 1'b1;
                end else if (start_press) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                // Death outranks any press seen in the same cycle.
                if (isDead) begin
                    state_nxt = S_DEAD;
                    die       = 1'b1;
                end else if (pause_press) begin
                    // Pause wins over a coincident flap so flap never shows up in PAUSE.
                    state_nxt = S_PAUSE;
                end else if (up_press) begin
                    flap_nxt = 1'b1;
                end
            end
            S_PAUSE: begin
                if (pause_press) begin
                    state_nxt = S_PLAY;
                end
            end
            S_DEAD: begin
                // A start press before the hold expires is simply lost.
                if (start_press && restart_ok) begin
                    state_nxt = S_IDLE;
                    rearm     = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            flap        <= 1'b0;
            final_score <= '0;
            best_score  <= '0;
            new_best    <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            state_q <= state_nxt;
            flap    <= flap_nxt;
            if (die) begin
                final_score <= score;
                if (score > best_score) begin
                    best_score <= score;
                    new_best   <= 1'b1;
                end else begin
                    new_best <= 1'b0;
                end
            end else if (rearm) begin
                new_best <= 1'b0;
            end
            if (die || rearm) begin
                hold_cnt <= '0;
            end else if (state_q == S_DEAD && tick_1ms && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end
        end
    end

    assign state      = state_q;
    assign restart_ok = (hold_cnt == HOLD_MAX);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: death/score table plus hand sequences for debounce, pause, simultaneous events, async reset.
// Latency: checks sampled on negedge, well after the responsible posedge.
// Backpressure: n/a (stimulus only).
module tb_game_flow_ctrl;

    localparam int TP = 2;  // clocks per tick_1ms

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       auto_tick = 1'b0;
    logic       man_tick = 1'b0;
    logic       tick_en = 1'b1;
    logic       tick_1ms;
    logic       btn_start = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_pause = 1'b0;
    logic       is_dead = 1'b0;
    logic [7:0] score_in = 8'd0;
    logic [1:0] state;
    logic       flap;
    logic [7:0] final_score;
    logic [7:0] best_score;
    logic       new_best;
    logic       restart_ok;

    assign tick_1ms = auto_tick | man_tick;

    game_flow_ctrl dut (
        .clk         (clk),
        .clrn        (clrn),
        .tick_1ms    (tick_1ms),
        .btn_start   (btn_start),
        .btn_up      (btn_up),
        .btn_pause   (btn_pause),
        .isDead      (is_dead),
        .score       (score_in),
        .state       (state),
        .flap        (flap),
        .final_score (final_score),
        .best_score  (best_score),
        .new_best    (new_best),
        .restart_ok  (restart_ok)
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    initial begin
        forever begin
            @(negedge clk);
            auto_tick = tick_en && (tdiv == TP - 1);
            tdiv = (tdiv + 1) % TP;
        end
    end

    int         flap_cnt = 0;
    int         flap_run = 0;
    int         flap_max = 0;
    int         idle2play = 0;
    logic [1:0] prev_state = 2'b00;
    initial begin
        forever begin
            @(negedge clk);
            if (flap === 1'b1) begin
                flap_cnt++;
                flap_run++;
            end else begin
                flap_run = 0;
            end
            if (flap_run > flap_max) flap_max = flap_run;
            if (prev_state == 2'b00 && state == 2'b01) idle2play++;
            prev_state = state;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TP) @(negedge clk);
    endtask

    // b: 0 start, 1 up, 2 pause. Holds, releases, then lets the release settle.
    task automatic press(input int b, input int hold);
        case (b)
            0: btn_start = 1'b1;
            1: btn_up    = 1'b1;
            default: btn_pause = 1'b1;
        endcase
        wait_ticks(hold);
        btn_start = 1'b0;
        btn_up    = 1'b0;
        btn_pause = 1'b0;
        wait_ticks(15);
    endtask

    task automatic die(input logic [7:0] s);
        score_in = s;
        is_dead  = 1'b1;
        @(negedge clk);
        is_dead = 1'b0;
    endtask

    // Called right after entering DEAD; exercises the discarded early start and the hold window.
    task automatic restart(input logic [7:0] exp_best);
        wait_ticks(400);
        press(0, 15);
        chk("early_start_state", state, 2'b10);
        chk("early_start_rok", restart_ok, 1'b0);
        wait_ticks(560);
        chk("rok_before_hold", restart_ok, 1'b0);
        wait_ticks(15);
        chk("rok_after_hold", restart_ok, 1'b1);
        chk("no_queued_start", state, 2'b10);
        chk("best_in_dead", best_score, exp_best);
        press(0, 15);
        chk("restart_state", state, 2'b00);
        chk("restart_new_best", new_best, 1'b0);
        chk("restart_rok", restart_ok, 1'b0);
        chk("restart_best", best_score, exp_best);
    endtask

    // isDead arrives in exactly the cycle the press event of button b is live.
    task automatic sim_dead(input int b, input logic [7:0] exp_best);
        int f0;
        f0 = flap_cnt;
        score_in = 8'd0;
        tick_en  = 1'b0;
        repeat (2) @(negedge clk);
        if (b == 1) btn_up = 1'b1;
        else btn_pause = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            man_tick = 1'b1;
            @(negedge clk);
            man_tick = 1'b0;
            if (i < 9) @(negedge clk);
        end
        is_dead = 1'b1;
        @(negedge clk);
        is_dead = 1'b0;
        chk(b == 1 ? "dead_up_state" : "dead_pause_state", state, 2'b10);
        repeat (3) @(negedge clk);
        chk(b == 1 ? "dead_up_flap" : "dead_pause_flap", flap_cnt - f0, 0);
        btn_up    = 1'b0;
        btn_pause = 1'b0;
        tick_en   = 1'b1;
        restart(exp_best);
    endtask

    typedef struct {
        logic [7:0] score;
        logic [7:0] fin;
        logic [7:0] best;
        logic       nb;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int f0;
        tbl[0] = '{score: 8'd20,  fin: 8'd20,  best: 8'd20,  nb: 1'b1};
        tbl[1] = '{score: 8'd37,  fin: 8'd37,  best: 8'd37,  nb: 1'b1};
        tbl[2] = '{score: 8'd37,  fin: 8'd37,  best: 8'd37,  nb: 1'b0};
        tbl[3] = '{score: 8'd5,   fin: 8'd5,   best: 8'd37,  nb: 1'b0};
        tbl[4] = '{score: 8'd200, fin: 8'd200, best: 8'd200, nb: 1'b1};
        tbl[5] = '{score: 8'd199, fin: 8'd199, best: 8'd200, nb: 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_state", state, 2'b00);
        chk("rst_flap", flap, 1'b0);
        chk("rst_final", final_score, 8'd0);
        chk("rst_best", best_score, 8'd0);
        chk("rst_new_best", new_best, 1'b0);
        chk("rst_rok", restart_ok, 1'b0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // long start hold: one IDLE->PLAY, no flap
        press(0, 15);
        chk("start_state", state, 2'b01);
        chk("start_once", idle2play, 1);
        chk("start_no_flap", flap_cnt, 0);

        // bounce train then steady hold on up: exactly one 1-clk flap
        f0 = flap_cnt;
        flap_max = 0;
        for (int i = 0; i < 4; i++) begin
            btn_up = (i % 2 == 0);
            wait_ticks(1);
        end
        btn_up = 1'b1;
        wait_ticks(12);
        btn_up = 1'b0;
        wait_ticks(15);
        chk("flap_count", flap_cnt - f0, 1);
        chk("flap_width", flap_max, 1);
        chk("flap_state", state, 2'b01);

        // pause / up ignored in pause / resume
        press(2, 15);
        chk("pause_state", state, 2'b11);
        f0 = flap_cnt;
        press(1, 15);
        chk("pause_up_state", state, 2'b11);
        chk("pause_up_flap", flap_cnt - f0, 0);
        press(2, 15);
        chk("resume_state", state, 2'b01);

        // isDead + pause press in the same cycle
        sim_dead(2, 8'd0);

        // death/score table
        for (int k = 0; k < 6; k++) begin
            press(0, 15);
            chk("tbl_play", state, 2'b01);
            die(tbl[k].score);
            chk("tbl_state", state, 2'b10);
            chk("tbl_final", final_score, tbl[k].fin);
            chk("tbl_best", best_score, tbl[k].best);
            chk("tbl_new_best", new_best, tbl[k].nb);
            chk("tbl_rok", restart_ok, 1'b0);
            restart(tbl[k].best);
        end

        // isDead + up press in the same cycle
        press(0, 15);
        sim_dead(1, 8'd200);

        // async reset mid-PAUSE
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_best", best_score, 8'd0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        press(0, 15);
        die(8'd50);
        chk("b50_best", best_score, 8'd50);
        chk("b50_new_best", new_best, 1'b1);
        restart(8'd50);
        press(0, 15);
        press(2, 15);
        chk("pre_rst_state", state, 2'b11);
        chk("pre_rst_best", best_score, 8'd50);
        @(posedge clk);
        #2;
        clrn = 1'b0;
        #1;
        chk("async_state", state, 2'b00);
        chk("async_best", best_score, 8'd0);
        chk("async_final", final_score, 8'd0);
        @(negedge clk);
        clrn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
